// File: rtl/regfile_issue.sv
// Register file with a one-entry issue register in front of the ALU.
// Operands are read (with same-cycle writeback bypass) when an issue is
// accepted and held in output registers until the ALU consumes them.
module regfile_issue #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ADDRBITS = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDRBITS-1:0] readAddr1,
  input  logic [ADDRBITS-1:0] readAddr2,
  input  logic [2:0]          command_in,
  input  logic                wrEnable,
  input  logic [ADDRBITS-1:0] wrAddr,
  input  logic [WIDTH-1:0]    wrData,
  output logic [WIDTH-1:0]    operandA,
  output logic [WIDTH-1:0]    operandB,
  output logic [2:0]          command,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int unsigned NumRegs = 1 << ADDRBITS;

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] regs_q [NumRegs];
  logic [WIDTH-1:0] rd_a, rd_b;
  logic             wr_go;
  logic             xfer_in, xfer_out, load;

  // Entry 0 is never written, so it stays at its reset value of zero.
  assign wr_go = wrEnable && (wrAddr != '0);

  // Register file storage; writes proceed every cycle independent of the pipeline.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NumRegs); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_go) begin
      regs_q[wrAddr] <= wrData;
    end
  end

  // Operand read with writeback bypass so an issue never captures a stale entry.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (readAddr1 != '0) begin
      rd_a = (wr_go && (wrAddr == readAddr1)) ? wrData : regs_q[readAddr1];
    end
    if (readAddr2 != '0) begin
      rd_b = (wr_go && (wrAddr == readAddr2)) ? wrData : regs_q[readAddr2];
    end
  end

  assign out_valid = (state_q == StFull);
  assign xfer_out  = out_valid && out_ready;

  // Handshake and EMPTY/FULL next-state logic.
  always_comb begin
    state_d  = state_q;
    in_ready = !out_valid || out_ready;
    xfer_in  = in_valid && in_ready;
    load     = xfer_in;
    unique case (state_q)
      StEmpty: begin
        if (xfer_in) state_d = StFull;
      end
      StFull: begin
        if (xfer_out && !xfer_in) state_d = StEmpty;
      end
      default: state_d = StEmpty;
    endcase
  end

  // Pipeline state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Issue registers load only on an accepted request and hold through stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      operandA <= '0;
      operandB <= '0;
      command  <= '0;
    end else if (load) begin
      operandA <= rd_a;
      operandB <= rd_b;
      command  <= command_in;
    end
  end

endmodule

// File: doc/regfile_issue.md
REGFILE_ISSUE -- requirements
Module: regfile_issue

Interface
REQ-001: Parameter WIDTH, default 32, data width of registers and ALU operands.
REQ-002: Parameter ADDRBITS, default 5, register address width; register count = 2^ADDRBITS.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: reset_n  input  1  reset, asynchronous and active-low.
REQ-005: in_valid  input  1  upstream presents an issue request.
REQ-006: in_ready  output  1  stage accepts an issue request this cycle.
REQ-007: readAddr1  input  ADDRBITS  source register for operandA.
REQ-008: readAddr2  input  ADDRBITS  source register for operandB.
REQ-009: command_in  input  3  ALU command code, ADD=0 SUB=1 XOR=2 SLT=3 AND=4 NAND=5 NOR=6 OR=7.
REQ-010: wrEnable  input  1  writeback strobe from the ALU result path.
REQ-011: wrAddr  input  ADDRBITS  writeback destination register.
REQ-012: wrData  input  WIDTH  writeback value.
REQ-013: operandA  output  WIDTH  registered operand A to the ALU.
REQ-014: operandB  output  WIDTH  registered operand B to the ALU.
REQ-015: command  output  3  registered ALU command.
REQ-016: out_valid  output  1  operandA/operandB/command hold a valid issue.
REQ-017: out_ready  input  1  ALU stage consumes the current issue.

Function
REQ-018: Register file SHALL hold 2^ADDRBITS entries of WIDTH bits; entry 0 SHALL always read 0 and SHALL ignore writes.
REQ-019: Write: on rising edge with wrEnable=1 and wrAddr!=0, entry wrAddr SHALL take wrData.
REQ-020: Read bypass: if wrEnable=1 and wrAddr==readAddrN!=0 in the issue cycle, operand N SHALL capture wrData, not the stale entry.
REQ-021: in_ready SHALL equal (!out_valid | out_ready), combinationally.
REQ-022: Transfer in occurs on a rising edge with in_valid & in_ready; then operandA, operandB, command SHALL load (read data incl. bypass, command_in) and out_valid SHALL become 1; latency one cycle from request to out_valid.
REQ-023: Transfer out occurs on a rising edge with out_valid & out_ready; if no simultaneous transfer in, out_valid SHALL become 0.
REQ-024: Simultaneous transfer out and in SHALL load the new issue with out_valid remaining 1 (full throughput, one issue per cycle).
REQ-025: Stall: while out_valid=1 and out_ready=0, operandA, operandB, command SHALL hold unchanged, even if the source registers are written.
REQ-026: Writes SHALL proceed every cycle regardless of stall or in_valid.
REQ-027: State: EMPTY (out_valid=0) and FULL (out_valid=1); EMPTY->FULL on transfer in; FULL->EMPTY on transfer out without transfer in; otherwise hold.
REQ-028: Output registers SHALL load only on transfer in; with in_valid=0 they keep their last values.

Reset
REQ-029: reset_n=0 SHALL immediately clear out_valid, operandA, operandB, command to 0 and all register entries to 0, regardless of clk.
REQ-030: Reset asserted mid-stall SHALL discard the held issue; after release the stage is EMPTY with in_ready=1.
REQ-031: Writes and transfers presented while reset_n=0 SHALL have no effect; the first edge after release operates normally.

Verification
REQ-032: Write r3=0x0000_0005, r4=0xFFFF_FFFF; issue readAddr1=3, readAddr2=4, command_in=1 -> next cycle operandA=0x5, operandB=0xFFFFFFFF, command=1, out_valid=1.
REQ-033: Write r0=0x1234 then issue readAddr1=0 -> operandA=0.
REQ-034: Same-cycle wrEnable=1, wrAddr=7, wrData=0xA5A5A5A5 with issue readAddr2=7 -> operandB=0xA5A5A5A5.
REQ-035: out_ready=0 for 3 cycles with in_valid=1 and r3 rewritten -> in_ready=0, outputs unchanged; out_ready=1 -> pending request accepted next edge.
REQ-036: Back-to-back issues with out_ready=1 held -> one new operand pair per cycle, out_valid stays 1, no drops or duplicates.
REQ-037: Assert reset_n=0 while FULL and stalled -> out_valid, operands, command and all entries 0 immediately; r5 reads 0 after release.
